// File: rtl/max7219_pkg.sv
// Shared constants, state encodings and command-word helper for the MAX7219 sequencer.
package max7219_pkg;

    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    localparam logic [2:0] INIT_LAST_STEP = 3'd4;
    localparam logic [2:0] ROW_LAST_STEP  = 3'd7;
    localparam logic [2:0] INIT_INTEN_STEP = 3'd3;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ROW,
        ST_INTEN
    } seq_state_e;

    typedef enum logic [1:0] {
        IS_IDLE,
        IS_ISSUE,
        IS_WAIT_BUSY,
        IS_WAIT_DONE
    } iss_state_e;

    function automatic logic [15:0] mk_cmd(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

endpackage

// File: rtl/max7219_cmd_issuer.sv
// Single-command handshake with the serial driver: wait ready, pulse start,
// see the driver go busy, then wait for it to go idle again.
module max7219_cmd_issuer
    import max7219_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] word,
    input  logic        drv_rdy,
    output logic        cmd_start,
    output logic [15:0] cmd_word,
    output logic        done
);

    iss_state_e  state_q, state_d;
    logic        start_q, start_d;
    logic [15:0] word_q, word_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IS_IDLE;
            start_q <= 1'b0;
            word_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        word_d  = word_q;
        done    = 1'b0;
        case (state_q)
            IS_IDLE, IS_ISSUE: begin
                // A request arriving while the driver is idle launches at once.
                if (req || (state_q == IS_ISSUE)) begin
                    if (drv_rdy) begin
                        start_d = 1'b1;
                        word_d  = word;
                        state_d = IS_WAIT_BUSY;
                    end else begin
                        state_d = IS_ISSUE;
                    end
                end
            end
            IS_WAIT_BUSY: begin
                if (!drv_rdy) state_d = IS_WAIT_DONE;
            end
            IS_WAIT_DONE: begin
                if (drv_rdy) begin
                    done    = 1'b1;
                    state_d = IS_IDLE;
                end
            end
            default: state_d = IS_IDLE;
        endcase
    end

    assign cmd_start = start_q;
    assign cmd_word  = word_q;

endmodule

// File: rtl/max7219_sequencer.sv
// Top sequencer: programs the MAX7219 after reset, streams 8-row frames,
// follows intensity changes and periodically re-initialises the chip.
module max7219_sequencer
    import max7219_pkg::*;
#(
    parameter logic [2:0]  SCAN_LIMIT    = 3'd7,
    parameter logic [7:0]  DECODE_MODE   = 8'h00,
    parameter logic [15:0] REINIT_FRAMES = 16'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [3:0]  intensity,
    input  logic        drv_rdy,
    output logic        cmd_start,
    output logic [15:0] cmd_word,
    output logic        init_done,
    output logic        busy
);

    seq_state_e  state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [63:0] frame_buf_q, frame_buf_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]  last_intensity_q, last_intensity_d;
    logic        init_done_q, init_done_d;

    logic        req;
    logic [15:0] req_word;
    logic        done;
    logic        reinit_due;
    logic        inten_change;
    logic [7:0]  row_byte [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_rows
        assign row_byte[gi] = frame_buf_q[8*gi +: 8];
    end

    assign reinit_due   = (REINIT_FRAMES != 16'd0) && (frame_cnt_q == REINIT_FRAMES);
    assign inten_change = (intensity != last_intensity_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_INIT;
            step_q           <= 3'd0;
            frame_buf_q      <= 64'd0;
            frame_cnt_q      <= 16'd0;
            last_intensity_q <= 4'd0;
            init_done_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            step_q           <= step_d;
            frame_buf_q      <= frame_buf_d;
            frame_cnt_q      <= frame_cnt_d;
            last_intensity_q <= last_intensity_d;
            init_done_q      <= init_done_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        step_d           = step_q;
        frame_buf_d      = frame_buf_q;
        frame_cnt_d      = frame_cnt_q;
        last_intensity_d = last_intensity_q;
        init_done_d      = init_done_q;
        frame_ready      = 1'b0;
        req              = 1'b0;
        req_word         = 16'h0000;
        case (state_q)
            ST_INIT: begin
                req = 1'b1;
                case (step_q)
                    3'd0:    req_word = mk_cmd(ADDR_TEST, 8'h00);
                    3'd1:    req_word = mk_cmd(ADDR_DECODE, DECODE_MODE);
                    3'd2:    req_word = mk_cmd(ADDR_SCANLIM, {5'd0, SCAN_LIMIT});
                    3'd3:    req_word = mk_cmd(ADDR_INTENSITY, {4'h0, intensity});
                    default: req_word = mk_cmd(ADDR_SHUTDOWN, 8'h01);
                endcase
                if (done) begin
                    // Remember the intensity that actually went out, not the live input.
                    if (step_q == INIT_INTEN_STEP) last_intensity_d = cmd_word[3:0];
                    if (step_q == INIT_LAST_STEP) begin
                        state_d     = ST_IDLE;
                        step_d      = 3'd0;
                        init_done_d = 1'b1;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (reinit_due) begin
                    frame_cnt_d = 16'd0;
                    state_d     = ST_INIT;
                    step_d      = 3'd0;
                end else if (inten_change) begin
                    state_d = ST_INTEN;
                end else begin
                    frame_ready = 1'b1;
                    if (frame_valid) begin
                        frame_buf_d = frame_data;
                        state_d     = ST_ROW;
                        step_d      = 3'd0;
                    end
                end
            end
            ST_ROW: begin
                req      = 1'b1;
                req_word = mk_cmd(ADDR_DIGIT0 + {1'b0, step_q}, row_byte[step_q]);
                if (done) begin
                    if (step_q == ROW_LAST_STEP) begin
                        state_d = ST_IDLE;
                        step_d  = 3'd0;
                        if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            ST_INTEN: begin
                req      = 1'b1;
                req_word = mk_cmd(ADDR_INTENSITY, {4'h0, intensity});
                if (done) begin
                    last_intensity_d = cmd_word[3:0];
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    max7219_cmd_issuer u_issuer (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .word      (req_word),
        .drv_rdy   (drv_rdy),
        .cmd_start (cmd_start),
        .cmd_word  (cmd_word),
        .done      (done)
    );

    assign init_done = init_done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_max7219_sequencer.sv
// Directed bench for max7219_sequencer with a simple busy-for-40-cycles driver model.
module tb_max7219_sequencer;
    import max7219_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] frame_data = 64'd0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [3:0]  intensity = 4'h5;
    logic        drv_rdy;
    logic        cmd_start;
    logic [15:0] cmd_word;
    logic        init_done;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] words_q [$];
    logic        drv_force_low = 1'b0;
    int          low_cnt = 0;

    max7219_sequencer #(
        .SCAN_LIMIT    (3'd7),
        .DECODE_MODE   (8'h00),
        .REINIT_FRAMES (16'd2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .intensity   (intensity),
        .drv_rdy     (drv_rdy),
        .cmd_start   (cmd_start),
        .cmd_word    (cmd_word),
        .init_done   (init_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Driver model: ready drops one cycle after a start and stays low for 40 cycles.
    initial begin
        drv_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (drv_force_low) begin
                drv_rdy = 1'b0;
                low_cnt = 0;
            end else if (low_cnt > 0) begin
                low_cnt = low_cnt - 1;
                drv_rdy = 1'b0;
            end else begin
                drv_rdy = 1'b1;
            end
            if (cmd_start && !drv_force_low) low_cnt = 40;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmd_start) begin
                words_q.push_back(cmd_word);
                $display("cmd_start word=%04h", cmd_word);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_words(input int n, input int budget, input string name);
        int cyc = 0;
        while (words_q.size() < n && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (words_q.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d words, required %0d", name, words_q.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int cyc = 0;
        while (busy !== 1'b0 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, cyc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rst_frame_ready: got %b want 0", frame_ready); end
        checks++; if (cmd_start !== 1'b0) begin errors++; $display("FAIL rst_cmd_start: got %b want 0", cmd_start); end
        checks++; if (cmd_word !== 16'h0000) begin errors++; $display("FAIL rst_cmd_word: got %04h want 0000", cmd_word); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
        words_q.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (cmd_start !== 1'b1) begin errors++; $display("FAIL first_start_latency: got %b want 1", cmd_start); end
        checks++; if (cmd_word !== 16'h0F00) begin errors++; $display("FAIL first_word: got %04h want 0F00", cmd_word); end
    endtask

    task automatic test_init();
        logic [15:0] exp [5];
        exp = '{16'h0F00, 16'h0900, 16'h0B07, 16'h0A05, 16'h0C01};
        wait_words(5, 3000, "init_words");
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early: got %b want 0", init_done); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (words_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL init_word%0d: got %04h want %04h", i, words_q[i], exp[i]);
            end
        end
        wait_idle(500, "init_idle");
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b want 1", init_done); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL init_frame_ready: got %b want 1", frame_ready); end
    endtask

    task automatic test_frame();
        logic [15:0] exp [8];
        int ready_bad = 0;
        int cyc = 0;
        exp = '{16'h0101, 16'h0202, 16'h0304, 16'h0408, 16'h0510, 16'h0620, 16'h0740, 16'h0880};
        words_q.delete();
        frame_data  = 64'h8040201008040201;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        frame_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL frame_ready_after_accept: got %b want 0", frame_ready); end
        @(posedge clk); #1;
        checks++; if (cmd_start !== 1'b1 || cmd_word !== 16'h0101) begin
            errors++; $display("FAIL frame_first_start: got start=%b word=%04h want 1/0101", cmd_start, cmd_word);
        end
        while ((words_q.size() < 8 || busy) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (busy && frame_ready) ready_bad++;
        end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL frame_ready_during_rows: got %0d high cycles want 0", ready_bad); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (words_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL frame_row%0d: got %04h want %04h", i, words_q[i], exp[i]);
            end
        end
        checks++; if (frame_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL frame_end_ready: got ready=%b busy=%b want 1/0", frame_ready, busy);
        end
    endtask

    task automatic test_inten_vs_frame();
        int cyc = 0;
        words_q.delete();
        intensity   = 4'hF;
        frame_valid = 1'b1;
        frame_data  = 64'h0123456789ABCDEF;
        #1;
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL inten_blocks_ready: got %b want 0", frame_ready); end
        while (frame_ready !== 1'b1 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (words_q.size() != 1 || words_q[0] !== 16'h0A0F) begin
            errors++; $display("FAIL inten_first: got %0d words first=%04h want 1 word 0A0F", words_q.size(), words_q[0]);
        end
        @(posedge clk); #1;
        frame_valid = 1'b0;
        cyc = 0;
        while ((words_q.size() < 9 || busy) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (words_q[1] !== 16'h01EF) begin errors++; $display("FAIL inten_frame_row0: got %04h want 01EF", words_q[1]); end
        checks++; if (words_q[8] !== 16'h0801) begin errors++; $display("FAIL inten_frame_row7: got %04h want 0801", words_q[8]); end
    endtask

    task automatic test_reinit();
        logic [15:0] exp [5];
        exp = '{16'h0F00, 16'h0900, 16'h0B07, 16'h0A0F, 16'h0C01};
        words_q.delete();
        checks++; if (busy !== 1'b0 || frame_ready !== 1'b0) begin
            errors++; $display("FAIL reinit_blocks_ready: got busy=%b ready=%b want 0/0", busy, frame_ready);
        end
        wait_words(5, 3000, "reinit_words");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (words_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL reinit_word%0d: got %04h want %04h", i, words_q[i], exp[i]);
            end
        end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reinit_init_done: got %b want 1", init_done); end
        wait_idle(500, "reinit_idle");
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL reinit_ready: got %b want 1", frame_ready); end
        words_q.delete();
        frame_data  = 64'h00000000000000FF;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        @(posedge clk); #1;
        wait_words(8, 3000, "frame3_words");
        wait_idle(500, "frame3_idle");
        checks++; if (words_q[0] !== 16'h01FF || words_q[7] !== 16'h0800) begin
            errors++; $display("FAIL frame3_rows: got %04h/%04h want 01FF/0800", words_q[0], words_q[7]);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || words_q.size() != 8) begin
            errors++; $display("FAIL frame3_no_reinit: got busy=%b words=%0d want 0/8", busy, words_q.size());
        end
    endtask

    task automatic test_mid_reset();
        int cyc = 0;
        words_q.delete();
        frame_data  = 64'h1122334455667788;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        while (!(words_q.size() >= 4 && drv_rdy === 1'b0) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (words_q[3] !== 16'h0455) begin errors++; $display("FAIL midrst_row3: got %04h want 0455", words_q[3]); end
        drv_force_low = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (cmd_start !== 1'b0 || cmd_word !== 16'h0000 || frame_ready !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL midrst_values: got start=%b word=%04h ready=%b init_done=%b busy=%b want 0/0000/0/0/1",
                               cmd_start, cmd_word, frame_ready, init_done, busy);
        end
        rst = 1'b0;
        words_q.delete();
        repeat (20) @(posedge clk);
        #1;
        checks++; if (words_q.size() != 0 || cmd_word !== 16'h0000) begin
            errors++; $display("FAIL midrst_hold: got words=%0d word=%04h want 0/0000", words_q.size(), cmd_word);
        end
        drv_force_low = 1'b0;
        wait_words(1, 200, "midrst_restart");
        checks++; if (words_q[0] !== 16'h0F00) begin errors++; $display("FAIL midrst_first: got %04h want 0F00", words_q[0]); end
        wait_idle(3000, "midrst_idle");
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL midrst_init_done: got %b want 1", init_done); end
    endtask

    task automatic test_slow_driver();
        int starts = 0;
        words_q.delete();
        drv_force_low = 1'b1;
        frame_data    = 64'hF0E0D0C0B0A09080;
        frame_valid   = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (cmd_start) starts++;
        end
        checks++; if (starts != 0) begin errors++; $display("FAIL slow_no_start: got %0d starts want 0", starts); end
        checks++; if (cmd_word !== 16'h0C01) begin errors++; $display("FAIL slow_word_stable: got %04h want 0C01", cmd_word); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL slow_busy: got %b want 1", busy); end
        drv_force_low = 1'b0;
        wait_words(8, 3000, "slow_words");
        checks++; if (words_q[0] !== 16'h0180 || words_q[7] !== 16'h08F0) begin
            errors++; $display("FAIL slow_rows: got %04h/%04h want 0180/08F0", words_q[0], words_q[7]);
        end
        wait_idle(500, "slow_idle");
    endtask

    initial begin
        test_reset();
        test_init();
        test_frame();
        test_inten_vs_frame();
        test_reinit();
        test_mid_reset();
        test_slow_driver();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/max7219_sequencer.md
# max7219_sequencer

Command sequencer between frame producers and the MAX7219 serial driver. After reset it programs the MAX7219 control registers (display test, decode mode, scan limit, intensity, shutdown). It then accepts 64-bit frames over a valid/ready handshake and issues the eight digit-register writes per frame, one 16-bit command at a time, paced by the driver's ready flag. It also applies runtime intensity changes and periodically re-runs initialization to recover from supply glitches.

## Interface
Parameters:
- `SCAN_LIMIT`, 3'd7: value written to the scan-limit register (0x0B).
- `DECODE_MODE`, 8'h00: value written to the decode-mode register (0x09).
- `REINIT_FRAMES`, 256: completed frames between automatic re-inits; 0 disables re-init; width 16 bits.

Ports:
- `clk` input 1: system clock (100 MHz).
- `rst` input 1: synchronous, active-high reset.
- `frame_data` input 64: row r = `frame_data[8r+7:8r]`, written to digit register r+1.
- `frame_valid` input 1: frame offered.
- `frame_ready` output 1: frame accepted on a cycle where valid && ready.
- `intensity` input 4: desired intensity (0x0A data, zero-extended).
- `drv_rdy` input 1: driver idle flag.
- `cmd_start` output 1: one-cycle pulse that launches a driver transfer.
- `cmd_word` output 16: `{4'h0, addr[3:0], data[7:0]}`.
- `init_done` output 1: high after the first init sequence completes.
- `busy` output 1: high whenever the sequencer is not in IDLE.

## Operation
- Reset values: `frame_ready`=0, `cmd_start`=0, `cmd_word`=16'h0000, `init_done`=0, `busy`=1. The frame counter and `last_intensity` clear to 0.
- Init list, in this order:
  - 0x0F00 (display test off)
  - 0x09 `DECODE_MODE`
  - 0x0B `SCAN_LIMIT`
  - 0x0A `intensity` (sampled at issue; stored in `last_intensity`)
  - 0x0C01 (normal operation)
- States:
  - INIT(i): i = 0..4, one command per step.
  - IDLE
  - ROW(r): r = 0..7.
  - INTEN
  - ISSUE, WAIT_BUSY, WAIT_DONE: the shared command handshake.
- Every command follows the same handshake:
  - ISSUE waits for `drv_rdy`=1, then pulses `cmd_start` and goes to WAIT_BUSY.
  - WAIT_BUSY waits for `drv_rdy`=0, then goes to WAIT_DONE.
  - WAIT_DONE waits for `drv_rdy`=1, then returns to the caller's next step.
- IDLE, priority order when several conditions hold:
  1. Frame counter equals `REINIT_FRAMES` (and `REINIT_FRAMES`≠0): clear the counter, run INIT(0..4), return to IDLE.
  2. `intensity` ≠ `last_intensity`: INTEN issues 0x0A command, updates `last_intensity`.
  3. `frame_valid`: accept the frame into an internal 64-bit buffer, run ROW(0..7), increment the counter (saturates at 16'hFFFF).
- `frame_ready` is high only in IDLE, and only when neither condition 1 nor condition 2 holds. Consequently, an intensity change arriving together with a frame delays acceptance of that frame.
- The frame buffer is written only on acceptance. `frame_data` changes during ROW have no effect.
- `init_done` rises once, at the completion of INIT(4) after reset. It stays high through re-inits.

## Timing
- `cmd_start` and `cmd_word` are registered outputs.
- `cmd_word` is valid in the `cmd_start` cycle and held until the next `cmd_start`.
- Frame accepted at edge t: the first `cmd_start` is asserted in cycle t+1 if `drv_rdy`=1.
- Back-to-back commands: the next `cmd_start` follows one cycle after `drv_rdy` returns to 1.
- The first init command issues at cycle 1 after `rst` deasserts, if `drv_rdy`=1.
- Reset mid-transfer aborts immediately. Init restarts only once `drv_rdy`=1, because ISSUE always waits for it.
- A `drv_rdy` glitch high during WAIT_BUSY has no effect.
- No timeout: a driver that never drops `drv_rdy` stalls the sequencer in WAIT_BUSY. This is by design.
- `busy` drops in the cycle IDLE is entered.

## Structure
- Package `max7219_pkg`:
  - register-address constants: `ADDR_DIGIT0`=1, `ADDR_DECODE`=9, `ADDR_INTENSITY`=0xA, `ADDR_SCANLIM`=0xB, `ADDR_SHUTDOWN`=0xC, `ADDR_TEST`=0xF;
  - state enum;
  - a `mk_cmd(addr, data)` function.
- One sub-module, `max7219_cmd_issuer`. It holds the ISSUE/WAIT_BUSY/WAIT_DONE handshake and exposes `req` and `word` inputs plus a one-cycle `done` output.
- The top FSM selects command words and counts steps.

## Test plan
- **Reset/init.** Driver model: `rdy` drops 1 cycle after start and stays low 40 cycles. Release `rst`, `intensity`=4'h5. Expected: words 0x0F00, 0x0900, 0x0B07, 0x0A05, 0x0C01 in order; `init_done` rises after the 5th `done`; `frame_ready`=1.
- **Frame.** `frame_data`=64'h8040201008040201. Expected: words 0x0101, 0x0202, 0x0304, 0x0408, 0x0510, 0x0620, 0x0740, 0x0880; `frame_ready` is low throughout and returns high afterwards.
- **Intensity vs. frame.** Change `intensity` to 4'hF in the same cycle `frame_valid` rises. Expected: 0x0A0F issued first, and the frame is accepted only afterwards.
- **Re-init.** `REINIT_FRAMES`=2; send 3 frames. Expected: the full 5-word init runs between frame 2 and frame 3; `init_done` stays 1.
- **Mid-sequence reset.** Assert `rst` during ROW(3) while `drv_rdy`=0. Expected: all outputs take reset values; no `cmd_start` until `drv_rdy`=1; then 0x0F00.
- **Slow driver.** Hold `drv_rdy`=0 for 1000 cycles. Expected: no `cmd_start`, no state advance, `cmd_word` stable.
